// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 encodings, unit state, and sign helper.
// Imported by the multiply/divide unit and its interface.
package rv32m_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    // Two's-complement negate when the caller flags the value as signed-negative.
    // Callers zero-extend into MAX_W and truncate the return back to their width.
    function automatic logic [MAX_W-1:0] abs_if_signed(input logic [MAX_W-1:0] x,
                                                       input logic             neg);
        return neg ? (~x + MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/rv32m_muldiv_if.sv
// Request/response handshake bundle between the EX stage and the mul/div unit.
interface rv32m_muldiv_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_WIDTH = 5
);
    logic                 i_valid;
    logic                 o_ready;
    logic [2:0]           i_op;
    logic [WIDTH-1:0]     i_rs1_data;
    logic [WIDTH-1:0]     i_rs2_data;
    logic [TAG_WIDTH-1:0] i_tag;
    logic                 i_flush;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH-1:0]     o_result;
    logic [TAG_WIDTH-1:0] o_tag;

    modport master (
        output i_valid, i_op, i_rs1_data, i_rs2_data, i_tag, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_tag
    );

    modport slave (
        input  i_valid, i_op, i_rs1_data, i_rs2_data, i_tag, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_tag
    );
endinterface

// File: rtl/rv32m_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle after start.
// done stays high once WIDTH iterations have completed, until the next start.
module rv32m_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic             active;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Top bit of diff is the borrow: set means the trial subtraction failed.
    always_comb begin
        shifted = {remainder, quotient[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_q};
        done    = active && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            active    <= 1'b0;
            divisor_q <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            cnt       <= CNT_W'(WIDTH);
            active    <= 1'b1;
            divisor_q <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/rv32m_muldiv.sv
// RV32M execute unit: fixed-latency multiply, iterative divide with fast paths,
// single operation in flight, valid/ready on both sides, tag pass-through, flush.
module rv32m_muldiv
    import rv32m_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned TAG_WIDTH   = 5
) (
    input logic         i_clk,
    input logic         i_rst,
    rv32m_muldiv_if.slave bus
);
    localparam int unsigned CNT_W    = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam int unsigned MUL_LAST = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 valid_q;
    logic [WIDTH-1:0]     result_q;

    logic             accept, in_signed, in_rem, div_zero, div_ovf, div_special, div_start;
    logic             div_done, sgn_q, rem_q;
    logic [WIDTH-1:0] special_res, dvd_abs, dvs_abs, quo, rem, q_fix, r_fix;

    // Low bits of the 2*WIDTH product are the same for any extension, so MUL
    // shares the MULH/MULHSU extension choice.
    function automatic logic [WIDTH-1:0] mul_fn(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ae;
        logic [2*WIDTH-1:0] be;
        logic [2*WIDTH-1:0] p;
        ae = {{WIDTH{(op != OP_MULHU) & a[WIDTH-1]}}, a};
        be = {{WIDTH{(op == OP_MULH) & b[WIDTH-1]}}, b};
        p  = ae * be;
        return (op == OP_MUL) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    always_comb begin
        accept      = bus.i_valid && (state == ST_IDLE) && !bus.i_flush;
        in_signed   = (bus.i_op == OP_DIV) || (bus.i_op == OP_REM);
        in_rem      = (bus.i_op == OP_REM) || (bus.i_op == OP_REMU);
        div_zero    = (bus.i_rs2_data == '0);
        div_ovf     = in_signed && (bus.i_rs1_data == MOST_NEG) && (bus.i_rs2_data == '1);
        div_special = div_zero || div_ovf;
        special_res = div_zero ? (in_rem ? bus.i_rs1_data : '1)
                               : (in_rem ? '0 : bus.i_rs1_data);
        div_start   = accept && bus.i_op[2] && !div_special;
        dvd_abs     = WIDTH'(abs_if_signed(MAX_W'(bus.i_rs1_data), in_signed && bus.i_rs1_data[WIDTH-1]));
        dvs_abs     = WIDTH'(abs_if_signed(MAX_W'(bus.i_rs2_data), in_signed && bus.i_rs2_data[WIDTH-1]));
        sgn_q       = (op_q == OP_DIV) || (op_q == OP_REM);
        rem_q       = (op_q == OP_REM) || (op_q == OP_REMU);
        // Quotient negative when signs differ; remainder follows the dividend.
        q_fix       = WIDTH'(abs_if_signed(MAX_W'(quo), sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])));
        r_fix       = WIDTH'(abs_if_signed(MAX_W'(rem), sgn_q && a_q[WIDTH-1]));
    end

    rv32m_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (div_start),
        .dividend  (dvd_abs),
        .divisor   (dvs_abs),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.i_flush) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.i_op;
                        a_q   <= bus.i_rs1_data;
                        b_q   <= bus.i_rs2_data;
                        tag_q <= bus.i_tag;
                        cnt   <= '0;
                        if (!bus.i_op[2]) begin
                            if (MUL_LATENCY == 1) begin
                                result_q <= mul_fn(bus.i_op, bus.i_rs1_data, bus.i_rs2_data);
                                valid_q  <= 1'b1;
                                state    <= ST_DONE;
                            end else begin
                                state <= ST_MUL;
                            end
                        end else if (div_special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt == CNT_W'(MUL_LAST)) begin
                        result_q <= mul_fn(op_q, a_q, b_q);
                        valid_q  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        result_q <= rem_q ? r_fix : q_fix;
                        valid_q  <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready  = (state == ST_IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_tag    = tag_q;
endmodule
